up_fifo_unpacker: RTL and testbench

Transmit-side width converter for the 32/16-bit FIFO link. It pops 32-bit words from a first-word-fall-through (FWFT) FIFO and writes them as two 16-bit halfwords into a 16-bit FIFO write port. It sustains one halfword per clock under no backpressure. It also keeps duplicate-word and word-count statistics for the debug ILA.

---
 rtl/up_fifo_unpacker.sv | 137 +++++++++++++
 tb/tb_up_fifo_unpacker.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/up_fifo_unpacker.sv
// up_fifo_unpacker: pops 32-bit words from an FWFT FIFO and writes them
// as two 16-bit halfwords, with word-count and duplicate-word statistics.
module up_fifo_unpacker #(
    parameter bit LOW_HALF_FIRST = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic        clear_i,
    input  logic [31:0] rd_data_i,
    input  logic        rd_empty_i,
    output logic        rd_en_o,
    output logic [15:0] wr_data_o,
    output logic        wr_en_o,
    input  logic        wr_full_i,
    output logic        busy_o,
    output logic [31:0] word_count_o,
    output logic [15:0] dup_count_o,
    output logic        dup_err_o
);

    typedef enum logic [1:0] {
        IDLE,
        SEND_FIRST,
        SEND_SECOND
    } state_t;

    state_t      state_q;
    logic [31:0] hold_q;
    logic [31:0] prev_q;
    logic [31:0] word_count_q;
    logic [15:0] dup_count_q;
    logic        dup_err_q;

    logic        take;
    logic        in_idle;
    logic        in_first;
    logic        in_second;
    logic        pop;
    logic        accept_word;
    logic        is_dup;
    logic [15:0] first_half;
    logic [15:0] second_half;

    // Handshake strobes; rd_en is held low while reset is asserted so no
    // word is popped (and lost) during reset.
    always_comb begin
        take        = enable_i & ~rd_empty_i;
        in_idle     = (state_q == IDLE);
        in_first    = (state_q == SEND_FIRST);
        in_second   = (state_q == SEND_SECOND);
        pop         = take & ~reset_i
                      & (in_idle | (in_second & ~wr_full_i));
        accept_word = in_second & ~wr_full_i;
        is_dup      = (rd_data_i == prev_q);
        if (LOW_HALF_FIRST) begin
            first_half  = hold_q[15:0];
            second_half = hold_q[31:16];
        end else begin
            first_half  = hold_q[31:16];
            second_half = hold_q[15:0];
        end
    end

    // Output halfword selection from the held word.
    always_comb begin
        wr_data_o = 16'h0000;
        if (in_first) begin
            wr_data_o = first_half;
        end else if (in_second) begin
            wr_data_o = second_half;
        end
    end

    assign rd_en_o      = pop;
    assign wr_en_o      = (in_first | in_second) & ~wr_full_i;
    assign busy_o       = ~in_idle;
    assign word_count_o = word_count_q;
    assign dup_count_o  = dup_count_q;
    assign dup_err_o    = dup_err_q;

    // Sequencer: load a word, emit first half, emit second half.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            hold_q  <= 32'h0000_0000;
            prev_q  <= 32'hFFFF_FFFF;
        end else begin
            if (pop) begin
                hold_q <= rd_data_i;
                prev_q <= rd_data_i;
            end
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_q <= SEND_FIRST;
                    end
                end
                SEND_FIRST: begin
                    if (!wr_full_i) begin
                        state_q <= SEND_SECOND;
                    end
                end
                SEND_SECOND: begin
                    if (!wr_full_i) begin
                        state_q <= pop ? SEND_FIRST : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Statistics; a clear in the same cycle as an update wins.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            word_count_q <= 32'h0000_0000;
            dup_count_q  <= 16'h0000;
            dup_err_q    <= 1'b0;
        end else if (clear_i) begin
            word_count_q <= 32'h0000_0000;
            dup_count_q  <= 16'h0000;
            dup_err_q    <= 1'b0;
        end else begin
            if (accept_word) begin
                word_count_q <= word_count_q + 32'd1;
            end
            if (pop && is_dup) begin
                dup_err_q <= 1'b1;
                if (dup_count_q != 16'hFFFF) begin
                    dup_count_q <= dup_count_q + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_up_fifo_unpacker.sv
// tb_up_fifo_unpacker: directed self-checking bench for up_fifo_unpacker.
// Inputs change at the falling edge; outputs are checked 1 time unit later.
module tb_up_fifo_unpacker;

    logic        clk;
    logic        reset_i;
    logic        enable_i;
    logic        clear_i;
    logic [31:0] rd_data_i;
    logic        rd_empty_i;
    logic        rd_en_o;
    logic [15:0] wr_data_o;
    logic        wr_en_o;
    logic        wr_full_i;
    logic        busy_o;
    logic [31:0] word_count_o;
    logic [15:0] dup_count_o;
    logic        dup_err_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] words [4];

    up_fifo_unpacker #(.LOW_HALF_FIRST(1'b1)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .enable_i     (enable_i),
        .clear_i      (clear_i),
        .rd_data_i    (rd_data_i),
        .rd_empty_i   (rd_empty_i),
        .rd_en_o      (rd_en_o),
        .wr_data_o    (wr_data_o),
        .wr_en_o      (wr_en_o),
        .wr_full_i    (wr_full_i),
        .busy_o       (busy_o),
        .word_count_o (word_count_o),
        .dup_count_o  (dup_count_o),
        .dup_err_o    (dup_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        reset_i    = 1'b1;
        enable_i   = 1'b0;
        clear_i    = 1'b0;
        rd_data_i  = 32'h0;
        rd_empty_i = 1'b1;
        wr_full_i  = 1'b0;
        words[0] = 32'hA000_0001;
        words[1] = 32'hB000_0002;
        words[2] = 32'hC000_0003;
        words[3] = 32'hD000_0004;

        // Reset values
        #2;
        chk("rst_rd_en", {31'd0, rd_en_o}, 32'd0);
        chk("rst_wr_en", {31'd0, wr_en_o}, 32'd0);
        chk("rst_wr_data", {16'd0, wr_data_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_wc", word_count_o, 32'd0);
        chk("rst_dup", {16'd0, dup_count_o}, 32'd0);
        chk("rst_err", {31'd0, dup_err_o}, 32'd0);

        // Single word, low half first
        @(negedge clk);
        reset_i    = 1'b0;
        enable_i   = 1'b1;
        rd_empty_i = 1'b0;
        rd_data_i  = 32'h1234_5678;
        #1;
        chk("t1_rd_en", {31'd0, rd_en_o}, 32'd1);
        chk("t1_wr_en0", {31'd0, wr_en_o}, 32'd0);
        @(negedge clk);
        rd_empty_i = 1'b1;
        #1;
        chk("t1_wr_en1", {31'd0, wr_en_o}, 32'd1);
        chk("t1_data1", {16'd0, wr_data_o}, 32'h5678);
        chk("t1_rd_en1", {31'd0, rd_en_o}, 32'd0);
        @(negedge clk);
        #1;
        chk("t1_wr_en2", {31'd0, wr_en_o}, 32'd1);
        chk("t1_data2", {16'd0, wr_data_o}, 32'h1234);
        @(negedge clk);
        #1;
        chk("t1_busy", {31'd0, busy_o}, 32'd0);
        chk("t1_wc", word_count_o, 32'd1);
        chk("t1_wr_en3", {31'd0, wr_en_o}, 32'd0);

        // Back-to-back stream of 4 words
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            rd_empty_i = (c >= 8);
            rd_data_i  = words[(c < 8) ? (c / 2) : 3];
            #1;
            chk("t2_rd_en", {31'd0, rd_en_o},
                {31'd0, ((c % 2) == 0) && (c < 8)});
            chk("t2_wr_en", {31'd0, wr_en_o}, {31'd0, c >= 1});
            if (c >= 1) begin
                chk("t2_data", {16'd0, wr_data_o},
                    {16'd0, (((c - 1) % 2) == 0)
                            ? words[(c - 1) / 2][15:0]
                            : words[(c - 1) / 2][31:16]});
            end
        end
        @(negedge clk);
        #1;
        chk("t2_wc", word_count_o, 32'd5);
        chk("t2_busy", {31'd0, busy_o}, 32'd0);
        chk("t2_dup", {16'd0, dup_count_o}, 32'd0);

        // Backpressure during the second half
        @(negedge clk);
        rd_empty_i = 1'b0;
        rd_data_i  = 32'hAABB_CCDD;
        #1;
        chk("t3_rd_en", {31'd0, rd_en_o}, 32'd1);
        @(negedge clk);
        rd_empty_i = 1'b1;
        #1;
        chk("t3_data1", {16'd0, wr_data_o}, 32'hCCDD);
        @(negedge clk);
        wr_full_i = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("t3_stall_wr_en", {31'd0, wr_en_o}, 32'd0);
            chk("t3_stall_data", {16'd0, wr_data_o}, 32'hAABB);
            chk("t3_stall_busy", {31'd0, busy_o}, 32'd1);
            @(negedge clk);
        end
        wr_full_i = 1'b0;
        #1;
        chk("t3_wr_en", {31'd0, wr_en_o}, 32'd1);
        chk("t3_data2", {16'd0, wr_data_o}, 32'hAABB);
        @(negedge clk);
        #1;
        chk("t3_wc", word_count_o, 32'd6);
        chk("t3_busy", {31'd0, busy_o}, 32'd0);

        // Duplicate word detection and clear
        @(negedge clk);
        rd_empty_i = 1'b0;
        rd_data_i  = 32'hDEAD_BEEF;
        #1;
        chk("t4_pop1", {31'd0, rd_en_o}, 32'd1);
        @(negedge clk);
        #1;
        chk("t4_sf_rd_en", {31'd0, rd_en_o}, 32'd0);
        chk("t4_dup0", {16'd0, dup_count_o}, 32'd0);
        @(negedge clk);
        #1;
        chk("t4_pop2", {31'd0, rd_en_o}, 32'd1);
        @(negedge clk);
        rd_empty_i = 1'b1;
        #1;
        chk("t4_dup1", {16'd0, dup_count_o}, 32'd1);
        chk("t4_err1", {31'd0, dup_err_o}, 32'd1);
        chk("t4_data", {16'd0, wr_data_o}, 32'hBEEF);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("t4_wc", word_count_o, 32'd8);
        @(negedge clk);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        #1;
        chk("t4_clr_wc", word_count_o, 32'd0);
        chk("t4_clr_dup", {16'd0, dup_count_o}, 32'd0);
        chk("t4_clr_err", {31'd0, dup_err_o}, 32'd0);

        // All-ones word right after reset matches prev reset value
        @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i    = 1'b0;
        rd_empty_i = 1'b0;
        rd_data_i  = 32'hFFFF_FFFF;
        #1;
        chk("t4b_pop", {31'd0, rd_en_o}, 32'd1);
        @(negedge clk);
        rd_empty_i = 1'b1;
        #1;
        chk("t4b_dup", {16'd0, dup_count_o}, 32'd1);
        chk("t4b_err", {31'd0, dup_err_o}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("t4b_wc", word_count_o, 32'd1);

        // Asynchronous reset while in the second half
        @(negedge clk);
        rd_empty_i = 1'b0;
        rd_data_i  = 32'h0102_0304;
        #1;
        chk("t5_pop", {31'd0, rd_en_o}, 32'd1);
        @(negedge clk);
        rd_empty_i = 1'b1;
        #1;
        chk("t5_data1", {16'd0, wr_data_o}, 32'h0304);
        @(negedge clk);
        rd_empty_i = 1'b0;
        rd_data_i  = 32'h5555_AAAA;
        #1;
        chk("t5_data2", {16'd0, wr_data_o}, 32'h0102);
        reset_i = 1'b1;
        #1;
        chk("t5_busy", {31'd0, busy_o}, 32'd0);
        chk("t5_wr_en", {31'd0, wr_en_o}, 32'd0);
        chk("t5_wr_data", {16'd0, wr_data_o}, 32'd0);
        chk("t5_rd_en", {31'd0, rd_en_o}, 32'd0);
        chk("t5_wc", word_count_o, 32'd0);
        chk("t5_dup", {16'd0, dup_count_o}, 32'd0);
        chk("t5_err", {31'd0, dup_err_o}, 32'd0);
        @(negedge clk);
        reset_i    = 1'b0;
        rd_empty_i = 1'b1;
        #1;
        chk("t5_post_wr0", {31'd0, wr_en_o}, 32'd0);
        @(negedge clk);
        #1;
        chk("t5_post_wr1", {31'd0, wr_en_o}, 32'd0);
        chk("t5_post_busy", {31'd0, busy_o}, 32'd0);

        // Enable dropped in the first half
        @(negedge clk);
        rd_empty_i = 1'b0;
        rd_data_i  = 32'h1111_2222;
        #1;
        chk("t6_pop", {31'd0, rd_en_o}, 32'd1);
        @(negedge clk);
        enable_i = 1'b0;
        #1;
        chk("t6_wr_en1", {31'd0, wr_en_o}, 32'd1);
        chk("t6_data1", {16'd0, wr_data_o}, 32'h2222);
        chk("t6_rd_en1", {31'd0, rd_en_o}, 32'd0);
        @(negedge clk);
        #1;
        chk("t6_wr_en2", {31'd0, wr_en_o}, 32'd1);
        chk("t6_data2", {16'd0, wr_data_o}, 32'h1111);
        chk("t6_rd_en2", {31'd0, rd_en_o}, 32'd0);
        @(negedge clk);
        #1;
        chk("t6_idle_rd", {31'd0, rd_en_o}, 32'd0);
        chk("t6_idle_busy", {31'd0, busy_o}, 32'd0);
        chk("t6_idle_wr", {31'd0, wr_en_o}, 32'd0);
        @(negedge clk);
        #1;
        chk("t6_idle_rd2", {31'd0, rd_en_o}, 32'd0);
        @(negedge clk);
        enable_i = 1'b1;
        #1;
        chk("t6_reen_rd", {31'd0, rd_en_o}, 32'd1);
        @(negedge clk);
        rd_empty_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("t6_wc", word_count_o, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
